// File: rtl/keypad_entry_pkg.sv
// Shared types and helpers for the keypad time-entry controller.
// Used by keypad_time_entry and keypad_edge_detect.
package keypad_entry_pkg;

    localparam int BCD_W = 4;
    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTRY  = 2'd1,
        COMMIT = 2'd2
    } entry_state_e;

    // Digits are valid BCD by construction, so nibble pairs compare as plain numbers.
    function automatic logic bcd_entry_valid(input logic [23:0] digits, input int ndigits);
        if (ndigits == 6) begin
            return (digits[23:16] <= HOUR_MAX) && (digits[15:8] <= MINSEC_MAX) &&
                   (digits[7:0] <= MINSEC_MAX);
        end
        return (digits[15:8] <= HOUR_MAX) && (digits[7:0] <= MINSEC_MAX);
    endfunction

endpackage

// File: rtl/keypad_edge_detect.sv
// Key/button event extraction: one-hot check and rising-edge pulses.
// KEYPAD_TIME_ENTRY_DEBOUNCE_EN adds a stability filter in front of the edge detect.
module keypad_edge_detect #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] keypad_buttons,
    input  logic       time_button,
    input  logic       alarm_button,
    output logic       key_event,
    output logic [3:0] key_digit,
    output logic       time_event,
    output logic       alarm_event
);
    logic [11:0] raw;
    logic [11:0] seen;
    logic [11:0] seen_q;
    logic        one_hot;

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYC must be at least 1");
    end

    assign raw = {alarm_button, time_button, keypad_buttons};

`ifdef KEYPAD_TIME_ENTRY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    logic [11:0]   raw_q;
    logic [11:0]   stable_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive cycles the whole pattern has held its value.
    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q    <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            raw_q <= raw;
            if (raw != raw_q) begin
                cnt_q <= CW'(1);
            end else begin
                if (cnt_q < CW'(DEBOUNCE_CYC)) cnt_q <= cnt_q + 1'b1;
                if (cnt_q >= CW'(DEBOUNCE_CYC - 1)) stable_q <= raw;
            end
        end
    end

    assign seen = stable_q;
`else
    assign seen = raw;
`endif

    always_ff @(posedge clk) begin
        if (reset) seen_q <= '0;
        else       seen_q <= seen;
    end

    // An event needs an idle keypad beforehand, so chords and held keys never re-arm it.
    assign one_hot   = (seen[9:0] != 10'd0) && ((seen[9:0] & (seen[9:0] - 10'd1)) == 10'd0);
    assign key_event = one_hot && (seen_q[9:0] == 10'd0);

    always_comb begin
        key_digit = '0;
        for (int k = 0; k < 10; k++) begin
            if (seen[k]) key_digit = 4'(k);
        end
    end

    assign time_event  = seen[10] & ~seen_q[10];
    assign alarm_event = seen[11] & ~seen_q[11];

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad entry controller: collects BCD digits, times out, validates and commits HH:MM[:SS].
// Optional KEYPAD_TIME_ENTRY_DEBOUNCE_EN debounces keys and buttons in keypad_edge_detect.
module keypad_time_entry
    import keypad_entry_pkg::*;
#(
    parameter int CLK_PER_SEC  = 256,
    parameter int TIMEOUT_SEC  = 10,
    parameter int NUM_DIGITS   = 4,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  keypad_buttons,
    input  logic                        time_button,
    input  logic                        alarm_button,
    output logic [BCD_W*NUM_DIGITS-1:0] entry_digits,
    output logic [2:0]                  entry_count,
    output logic                        show_entry,
    output logic [BCD_W*NUM_DIGITS-1:0] load_value,
    output logic                        time_load,
    output logic                        alarm_load,
    output logic                        entry_error
);
    localparam int DW        = BCD_W * NUM_DIGITS;
    localparam int TMO_TOTAL = TIMEOUT_SEC * CLK_PER_SEC;
    localparam int TMO_W     = $clog2(TMO_TOTAL + 1);
    localparam logic [TMO_W-1:0] TMO_RELOAD = TMO_W'(TMO_TOTAL);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_ENTRY  = 2'(ENTRY);
    localparam logic [1:0] S_COMMIT = 2'(COMMIT);

    if (NUM_DIGITS != 4 && NUM_DIGITS != 6) begin : g_bad_digits
        $error("NUM_DIGITS must be 4 or 6");
    end

    logic             key_event;
    logic [3:0]       key_digit;
    logic             time_event;
    logic             alarm_event;
    logic [1:0]       state_q;
    logic [TMO_W-1:0] tmo_q;
    logic [DW-1:0]    shifted;
    logic [23:0]      digits_ext;
    logic             commit_ok;

    keypad_edge_detect #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_edge (
        .clk            (clk),
        .reset          (reset),
        .keypad_buttons (keypad_buttons),
        .time_button    (time_button),
        .alarm_button   (alarm_button),
        .key_event      (key_event),
        .key_digit      (key_digit),
        .time_event     (time_event),
        .alarm_event    (alarm_event)
    );

    assign shifted    = {entry_digits[DW-BCD_W-1:0], key_digit};
    assign digits_ext = 24'(entry_digits);
    assign commit_ok  = (entry_count == 3'(NUM_DIGITS)) && bcd_entry_valid(digits_ext, NUM_DIGITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            entry_digits <= '0;
            entry_count  <= '0;
            show_entry   <= 1'b0;
            load_value   <= '0;
            time_load    <= 1'b0;
            alarm_load   <= 1'b0;
            entry_error  <= 1'b0;
        end else begin
            time_load   <= 1'b0;
            alarm_load  <= 1'b0;
            entry_error <= 1'b0;
            load_value  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (key_event) begin
                        entry_digits <= shifted;
                        entry_count  <= 3'd1;
                        show_entry   <= 1'b1;
                        tmo_q        <= TMO_RELOAD;
                        state_q      <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    // Buttons outrank a same-cycle key; time outranks alarm.
                    if (time_event || alarm_event) begin
                        state_q <= S_COMMIT;
                        if (commit_ok) begin
                            load_value <= entry_digits;
                            time_load  <= time_event;
                            alarm_load <= ~time_event;
                        end else begin
                            entry_error <= 1'b1;
                        end
                    end else if (key_event) begin
                        entry_digits <= shifted;
                        entry_count  <= (entry_count == 3'(NUM_DIGITS)) ? entry_count
                                                                        : entry_count + 3'd1;
                        tmo_q        <= TMO_RELOAD;
                    end else if (tmo_q <= TMO_W'(1)) begin
                        entry_digits <= '0;
                        entry_count  <= '0;
                        show_entry   <= 1'b0;
                        tmo_q        <= '0;
                        state_q      <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q - 1'b1;
                    end
                end
                S_COMMIT: begin
                    entry_digits <= '0;
                    entry_count  <= '0;
                    show_entry   <= 1'b0;
                    tmo_q        <= '0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Directed and randomized bench for keypad_time_entry against a digit-queue reference model.
// Honours KEYPAD_TIME_ENTRY_DEBOUNCE_EN by shifting the expected key/button latency.
module tb_keypad_time_entry;
    localparam int ND    = 4;
    localparam int DW    = 4 * ND;
    localparam int T_CYC = 10 * 256;
`ifdef KEYPAD_TIME_ENTRY_DEBOUNCE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [9:0]    keypad_buttons = '0;
    logic          time_button = 1'b0;
    logic          alarm_button = 1'b0;
    logic [DW-1:0] entry_digits;
    logic [2:0]    entry_count;
    logic          show_entry;
    logic [DW-1:0] load_value;
    logic          time_load;
    logic          alarm_load;
    logic          entry_error;

    int checks = 0;
    int failures = 0;
    int tl_cnt = 0;
    int al_cnt = 0;
    int er_cnt = 0;
    int q[$];

    keypad_time_entry #(
        .CLK_PER_SEC(256), .TIMEOUT_SEC(10), .NUM_DIGITS(ND), .DEBOUNCE_CYC(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .keypad_buttons (keypad_buttons),
        .time_button    (time_button),
        .alarm_button   (alarm_button),
        .entry_digits   (entry_digits),
        .entry_count    (entry_count),
        .show_entry     (show_entry),
        .load_value     (load_value),
        .time_load      (time_load),
        .alarm_load     (alarm_load),
        .entry_error    (entry_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (time_load)   tl_cnt++;
            if (alarm_load)  al_cnt++;
            if (entry_error) er_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_pack();
        logic [DW-1:0] v = '0;
        foreach (q[i]) v = {v[DW-5:0], 4'(q[i])};
        return v;
    endfunction

    function automatic bit model_valid();
        if (q.size() != ND) return 1'b0;
        if (q[0] * 10 + q[1] > 23) return 1'b0;
        if (q[2] * 10 + q[3] > 59) return 1'b0;
        if (ND == 6) begin
            if (q[4] * 10 + q[5] > 59) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic press(input int d, input int hold);
        @(posedge clk); #1;
        keypad_buttons    = '0;
        keypad_buttons[d] = 1'b1;
        repeat (1 + LAT) @(posedge clk); #1;
        q.push_back(d);
        if (q.size() > ND) void'(q.pop_front());
        check("key_digits", 64'(entry_digits), 64'(model_pack()));
        check("key_count", 64'(entry_count), 64'(q.size()));
        check("key_show", 64'(show_entry), 64'd1);
        repeat (hold - 1 - LAT) @(posedge clk); #1;
        keypad_buttons = '0;
        repeat (10) @(posedge clk);
    endtask

    task automatic button(input bit t, input bit a);
        int tl0, al0, er0;
        bit had, ok;
        logic [DW-1:0] exp_v;
        had = (q.size() != 0);
        ok = model_valid();
        exp_v = model_pack();
        tl0 = tl_cnt; al0 = al_cnt; er0 = er_cnt;
        @(posedge clk); #1;
        time_button  = t;
        alarm_button = a;
        repeat (1 + LAT) @(posedge clk); #1;
        if (!had) begin
            check("idle_show", 64'(show_entry), 64'd0);
            check("idle_count", 64'(entry_count), 64'd0);
        end else begin
            check("commit_time_load", 64'(time_load), 64'(t && ok));
            check("commit_alarm_load", 64'(alarm_load), 64'(!t && ok));
            check("commit_error", 64'(entry_error), 64'(!ok));
            check("commit_value", 64'(load_value), ok ? 64'(exp_v) : 64'd0);
        end
        @(posedge clk); #1;
        check("post_time_load", 64'(time_load), 64'd0);
        check("post_alarm_load", 64'(alarm_load), 64'd0);
        check("post_error", 64'(entry_error), 64'd0);
        check("post_show", 64'(show_entry), 64'd0);
        check("post_count", 64'(entry_count), 64'd0);
        check("post_digits", 64'(entry_digits), 64'd0);
        repeat (6) @(posedge clk); #1;
        time_button  = 1'b0;
        alarm_button = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("n_time_load", 64'(tl_cnt - tl0), 64'(had && t && ok));
        check("n_alarm_load", 64'(al_cnt - al0), 64'(had && !t && ok));
        check("n_error", 64'(er_cnt - er0), 64'(had && !ok));
        q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_digits"}, 64'(entry_digits), 64'd0);
        check({tag, "_count"}, 64'(entry_count), 64'd0);
        check({tag, "_show"}, 64'(show_entry), 64'd0);
        check({tag, "_load_value"}, 64'(load_value), 64'd0);
        check({tag, "_pulses"}, 64'({time_load, alarm_load, entry_error}), 64'd0);
    endtask

    initial begin
        int snap;
        repeat (3) @(posedge clk); #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Valid time commit 04:35
        press(0, 10); press(4, 10); press(3, 10); press(5, 10);
        button(1'b1, 1'b0);

        // Timeout with no button
        snap = tl_cnt + al_cnt + er_cnt;
        press(6, 10); press(7, 10); press(8, 10); press(9, 10);
        repeat (T_CYC - 1 - (19 - LAT)) @(posedge clk); #1;
        check("tmo_show_before", 64'(show_entry), 64'd1);
        check("tmo_digits_before", 64'(entry_digits), 64'(model_pack()));
        @(posedge clk); #1;
        check("tmo_show_after", 64'(show_entry), 64'd0);
        check("tmo_digits_after", 64'(entry_digits), 64'd0);
        check("tmo_count_after", 64'(entry_count), 64'd0);
        check("tmo_no_pulse", 64'(tl_cnt + al_cnt + er_cnt - snap), 64'd0);
        q.delete();

        // Invalid hour rejected, then valid alarm 05:37
        press(2, 10); press(5, 10); press(0, 10); press(0, 10);
        button(1'b0, 1'b1);
        press(0, 10); press(5, 10); press(3, 10); press(7, 10);
        button(1'b0, 1'b1);

        // Saturation, held key, multi-key chord
        press(1, 10); press(2, 10); press(3, 10); press(4, 10); press(5, 10);
        press(1, 50);
        @(posedge clk); #1;
        keypad_buttons = 10'h011;
        repeat (10) @(posedge clk); #1;
        keypad_buttons = '0;
        repeat (10) @(posedge clk); #1;
        check("chord_digits", 64'(entry_digits), 64'(model_pack()));
        check("chord_count", 64'(entry_count), 64'(q.size()));
        button(1'b1, 1'b0);

        // Simultaneous buttons, then alarm button in idle
        press(0, 10); press(4, 10); press(3, 10); press(5, 10);
        button(1'b1, 1'b1);
        button(1'b0, 1'b1);

        // Reset mid-entry, then a full timeout window with no pulse
        press(1, 10); press(2, 10);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        q.delete();
        snap = tl_cnt + al_cnt + er_cnt;
        repeat (T_CYC + 100) @(posedge clk); #1;
        check("post_reset_show", 64'(show_entry), 64'd0);
        check("post_reset_no_pulse", 64'(tl_cnt + al_cnt + er_cnt - snap), 64'd0);

`ifdef KEYPAD_TIME_ENTRY_DEBOUNCE_EN
        @(posedge clk); #1;
        keypad_buttons = 10'h008;
        repeat (2) @(posedge clk); #1;
        keypad_buttons = '0;
        repeat (20) @(posedge clk); #1;
        check("glitch_count", 64'(entry_count), 64'd0);
        check("glitch_show", 64'(show_entry), 64'd0);
`endif

        // Randomized entries, mostly well-formed times
        for (int it = 0; it < 16; it++) begin
            int n, hh, mm, sel;
            if ($urandom_range(0, 1) == 1) begin
                n  = $urandom_range(4, 6);
                hh = $urandom_range(0, 23);
                mm = $urandom_range(0, 59);
                for (int k = 0; k < n - 4; k++) press($urandom_range(0, 9), 10);
                press(hh / 10, 10); press(hh % 10, 10);
                press(mm / 10, 10); press(mm % 10, 10);
            end else begin
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) press($urandom_range(0, 9), 10);
            end
            sel = $urandom_range(0, 2);
            button(sel != 1, sel != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
